// File: rtl/fft_in_pack8_if.sv
// rtl/fft_in_pack8_if.sv - sample stream in, packed 8-vector out, for the FFT input packer
// The master side feeds samples and accepts vectors; the slave side is the packer itself.
interface fft_in_pack8_if #(
    parameter int DATA_INP_WD = 16
);
    logic                       val_i;
    logic                       rdy_o;
    logic                       sop_i;
    logic                       flush_i;
    logic [DATA_INP_WD-1:0]     dat_re_i;
    logic [DATA_INP_WD-1:0]     dat_im_i;
    logic                       val_o;
    logic                       rdy_i;
    logic [8*DATA_INP_WD-1:0]   dat_fft_re_o;
    logic [8*DATA_INP_WD-1:0]   dat_fft_im_o;
    logic                       drop_o;

    modport master (
        output val_i, sop_i, flush_i, dat_re_i, dat_im_i, rdy_i,
        input  rdy_o, val_o, dat_fft_re_o, dat_fft_im_o, drop_o
    );

    modport slave (
        input  val_i, sop_i, flush_i, dat_re_i, dat_im_i, rdy_i,
        output rdy_o, val_o, dat_fft_re_o, dat_fft_im_o, drop_o
    );
endinterface

// File: rtl/fft_in_pack8.sv
// rtl/fft_in_pack8.sv - ping-pong packer writing 8-sample blocks in bit-reversed slot order
// One bank fills from the sample stream while the other is presented to the FFT core.
module fft_in_pack8 #(
    parameter int DATA_INP_WD = 16
) (
    input  logic            clk,
    input  logic            rst,
    fft_in_pack8_if.slave   bus
);
    localparam int W = DATA_INP_WD;

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } state_t;

    state_t         state;
    logic [1:0]     full;
    logic [1:0]     full_nxt;
    logic           wr_bank;
    logic           rd_bank;
    logic [2:0]     wr_cnt;
    logic [2:0]     cnt_nxt;
    logic           drop_q;
    logic [W-1:0]   bank_re [2][8];
    logic [W-1:0]   bank_im [2][8];

    logic           rdy;
    logic           accept;
    logic           restart;
    logic           wr_en;
    logic           blk_done;
    logic           drain;
    logic           go_pad;
    logic [2:0]     wr_slot;
    logic [W-1:0]   wr_re;
    logic [W-1:0]   wr_im;

    function automatic logic [2:0] bitrev3(input logic [2:0] c);
        return {c[0], c[1], c[2]};
    endfunction

    assign rdy        = !rst && !full[wr_bank] && (state == FILL);
    assign drain      = full[rd_bank] && bus.rdy_i;
    assign bus.rdy_o  = rdy;
    assign bus.val_o  = full[rd_bank];
    assign bus.drop_o = drop_q;

    for (genvar k = 0; k < 8; k++) begin : g_pack
        assign bus.dat_fft_re_o[k*W +: W] = bank_re[rd_bank][k];
        assign bus.dat_fft_im_o[k*W +: W] = bank_im[rd_bank][k];
    end

    // A sop on a partially filled bank restarts it at slot 0; stale slots get overwritten later.
    always_comb begin
        accept   = bus.val_i && rdy;
        restart  = accept && bus.sop_i && (wr_cnt != 3'd0);
        wr_en    = accept || (state == PAD);
        wr_slot  = restart ? 3'd0 : bitrev3(wr_cnt);
        wr_re    = (state == PAD) ? '0 : bus.dat_re_i;
        wr_im    = (state == PAD) ? '0 : bus.dat_im_i;
        blk_done = wr_en && !restart && (wr_cnt == 3'd7);
        if (restart)
            cnt_nxt = 3'd1;
        else if (wr_en)
            cnt_nxt = wr_cnt + 3'd1;
        else
            cnt_nxt = wr_cnt;
        go_pad   = (state == FILL) && bus.flush_i && (cnt_nxt != 3'd0);
        full_nxt = full;
        if (drain)
            full_nxt[rd_bank] = 1'b0;
        if (blk_done)
            full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= 3'd0;
            drop_q  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < 8; s++) begin
                    bank_re[b][s] <= '0;
                    bank_im[b][s] <= '0;
                end
            end
        end else begin
            full   <= full_nxt;
            wr_cnt <= cnt_nxt;
            drop_q <= restart;
            if (blk_done)
                wr_bank <= ~wr_bank;
            if (drain)
                rd_bank <= ~rd_bank;
            if (wr_en) begin
                bank_re[wr_bank][wr_slot] <= wr_re;
                bank_im[wr_bank][wr_slot] <= wr_im;
            end
            case (state)
                FILL: if (go_pad) state <= PAD;
                PAD:  if (blk_done) state <= FILL;
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_in_pack8.sv
// tb/tb_fft_in_pack8.sv - directed and randomized bench for fft_in_pack8
// Reference model keeps sample blocks in queues and places sample n at the bit-reversed slot.
module tb_fft_in_pack8;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_in_pack8_if #(.DATA_INP_WD(W)) bus ();

    fft_in_pack8 #(.DATA_INP_WD(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total = 0;
    int failed = 0;
    int drop_cnt = 0;
    int exp_drops = 0;
    bit rand_rdy = 0;
    logic [255:0] got_q[$];
    logic [255:0] exp_q[$];
    logic [15:0]  cur_re[$];
    logic [15:0]  cur_im[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.val_o && bus.rdy_i)
                got_q.push_back({bus.dat_fft_re_o, bus.dat_fft_im_o});
            if (bus.drop_o)
                drop_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy)
            bus.rdy_i = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic emit();
        logic [127:0] vr;
        logic [127:0] vi;
        vr = '0;
        vi = '0;
        while (cur_re.size() < 8) begin
            cur_re.push_back(16'h0);
            cur_im.push_back(16'h0);
        end
        for (int n = 0; n < 8; n++) begin
            int slot;
            slot = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            vr[slot*16 +: 16] = cur_re[n];
            vi[slot*16 +: 16] = cur_im[n];
        end
        exp_q.push_back({vr, vi});
        cur_re.delete();
        cur_im.delete();
    endtask

    task automatic model_accept(input logic [15:0] re, input logic [15:0] im, input bit sop, input bit flush);
        if (sop && cur_re.size() != 0) begin
            cur_re.delete();
            cur_im.delete();
            exp_drops++;
        end
        cur_re.push_back(re);
        cur_im.push_back(im);
        if (cur_re.size() == 8 || flush)
            emit();
    endtask

    task automatic model_flush();
        if (cur_re.size() != 0)
            emit();
    endtask

    task automatic send(input logic [15:0] re, input logic [15:0] im, input bit sop, input bit flush);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        bus.val_i = 1'b1;
        bus.dat_re_i = re;
        bus.dat_im_i = im;
        bus.sop_i = sop;
        bus.flush_i = flush;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.rdy_o;
            step();
            n++;
        end
        bus.val_i = 1'b0;
        bus.sop_i = 1'b0;
        bus.flush_i = 1'b0;
        if (!acc)
            chk("send_timeout", 256'(acc), 256'(1));
        else
            model_accept(re, im, sop, flush);
    endtask

    task automatic send_rand();
        send(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic flush_pulse();
        bus.flush_i = 1'b1;
        @(negedge clk);
        step();
        bus.flush_i = 1'b0;
        model_flush();
    endtask

    task automatic check_vectors(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin
            step();
            n++;
        end
        idle(4);
        chk({tag, "_count"}, 256'(got_q.size()), 256'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int t1[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int t3[8] = '{1, 0, 3, 0, 2, 0, 0, 0};
        logic [127:0] e;
        logic [255:0] snap;
        logic [15:0] r17;
        logic [15:0] i17;
        int d0;

        bus.val_i = 1'b0;
        bus.sop_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.dat_re_i = '0;
        bus.dat_im_i = '0;
        bus.rdy_i = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 256'(bus.rdy_o), 256'(0));
        chk("rst_val", 256'(bus.val_o), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 256'(bus.rdy_o), 256'(1));
        chk("post_rst_val", 256'(bus.val_o), 256'(0));
        chk("post_rst_data", {bus.dat_fft_re_o, bus.dat_fft_im_o}, 256'(0));
        step();

        // 1: ramp, bit-reversed slots, one-cycle val_o
        for (int n = 0; n < 8; n++)
            send(16'(n), 16'(-n), 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_val_hi", 256'(bus.val_o), 256'(1));
        e = '0;
        for (int k = 0; k < 8; k++)
            e[k*16 +: 16] = 16'(t1[k]);
        chk("t1_re_slots", 256'(bus.dat_fft_re_o), 256'(e));
        step();
        @(negedge clk);
        chk("t1_val_lo", 256'(bus.val_o), 256'(0));
        step();
        check_vectors("t1");

        // 2: both banks fill under backpressure
        bus.rdy_i = 1'b0;
        for (int n = 0; n < 16; n++)
            send_rand();
        r17 = 16'($urandom);
        i17 = 16'($urandom);
        bus.val_i = 1'b1;
        bus.dat_re_i = r17;
        bus.dat_im_i = i17;
        @(negedge clk);
        chk("t2_rdy_lo", 256'(bus.rdy_o), 256'(0));
        chk("t2_val_hi", 256'(bus.val_o), 256'(1));
        snap = {bus.dat_fft_re_o, bus.dat_fft_im_o};
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            chk("t2_rdy_held", 256'(bus.rdy_o), 256'(0));
            chk("t2_stable", {bus.dat_fft_re_o, bus.dat_fft_im_o}, snap);
        end
        step();
        bus.rdy_i = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("t2_rdy_back", 256'(bus.rdy_o), 256'(1));
        step();
        bus.val_i = 1'b0;
        model_accept(r17, i17, 1'b0, 1'b0);
        for (int n = 0; n < 7; n++)
            send_rand();
        check_vectors("t2");

        // 3: partial block closed by flush
        send(16'd1, 16'($urandom), 1'b0, 1'b0);
        send(16'd2, 16'($urandom), 1'b0, 1'b0);
        send(16'd3, 16'($urandom), 1'b0, 1'b0);
        flush_pulse();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_pad_rdy", 256'(bus.rdy_o), 256'(0));
            step();
        end
        @(negedge clk);
        chk("t3_rdy_back", 256'(bus.rdy_o), 256'(1));
        chk("t3_val", 256'(bus.val_o), 256'(1));
        e = '0;
        for (int k = 0; k < 8; k++)
            e[k*16 +: 16] = 16'(t3[k]);
        chk("t3_re_slots", 256'(bus.dat_fft_re_o), 256'(e));
        step();
        check_vectors("t3");

        // 4: sop mid-block discards the partial block
        d0 = drop_cnt;
        for (int n = 0; n < 5; n++)
            send_rand();
        send(16'd9, 16'($urandom), 1'b1, 1'b0);
        for (int n = 0; n < 7; n++)
            send_rand();
        idle(2);
        chk("t4_drop_once", 256'(drop_cnt - d0), 256'(1));
        check_vectors("t4");

        // 5: reset with one bank full and the other half filled
        bus.rdy_i = 1'b0;
        for (int n = 0; n < 12; n++)
            send_rand();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rdy_in_rst", 256'(bus.rdy_o), 256'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_val", 256'(bus.val_o), 256'(0));
        chk("t5_rdy", 256'(bus.rdy_o), 256'(1));
        chk("t5_data", {bus.dat_fft_re_o, bus.dat_fft_im_o}, 256'(0));
        cur_re.delete();
        cur_im.delete();
        exp_q.delete();
        got_q.delete();
        step();
        bus.rdy_i = 1'b1;
        idle(20);
        chk("t5_no_stale", 256'(got_q.size()), 256'(0));

        // 6: flush on empty block and on the 8th accept are both ignored
        flush_pulse();
        @(negedge clk);
        chk("t6_empty_flush_rdy", 256'(bus.rdy_o), 256'(1));
        step();
        for (int n = 0; n < 7; n++)
            send_rand();
        send(16'($urandom), 16'($urandom), 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_last_flush_rdy", 256'(bus.rdy_o), 256'(1));
        step();
        check_vectors("t6");

        // randomized traffic with sop, flush and ready jitter
        rand_rdy = 1;
        for (int n = 0; n < 60; n++) begin
            send(16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
            if ($urandom_range(0, 7) == 0)
                flush_pulse();
        end
        flush_pulse();
        rand_rdy = 0;
        bus.rdy_i = 1'b1;
        check_vectors("rand");
        chk("drop_total", 256'(drop_cnt), 256'(exp_drops));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
